// File: rtl/aes_cntrl_parser_if.sv
// Control-stream bundle between the AXI DMA MM2S control port
// and the AES control parser.
interface aes_cntrl_parser_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/aes_cntrl_parser.sv
// Decodes DMA MM2S control frames into AES key/IV loads and start
// commands; malformed frames are drained and counted.
module aes_cntrl_parser #(
    parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
    parameter int C_KEY_WIDTH                     = 128,
    parameter int C_ERR_CNT_WIDTH                 = 8
) (
    input  logic                       m_axi_mm2s_aclk,
    input  logic                       mm2s_cntrl_reset,
    aes_cntrl_parser_if.slave          m_axis_mm2s_cntrl,
    output logic [C_KEY_WIDTH-1:0]     aes_key,
    output logic                       aes_key_load,
    output logic [C_KEY_WIDTH-1:0]     aes_iv,
    output logic                       aes_iv_load,
    output logic                       aes_cmd_valid,
    output logic                       aes_cmd_dir,
    input  logic                       aes_cmd_ready,
    output logic                       aes_cntrl_err,
    output logic [C_ERR_CNT_WIDTH-1:0] aes_cntrl_err_cnt
);
    localparam int DW    = C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH;
    localparam int BEATS = C_KEY_WIDTH / DW;

    localparam logic [2:0] LAST_BEAT = 3'(BEATS);
    localparam logic [C_ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_FLAG,
        S_APP0,
        S_PAYLOAD,
        S_DRAIN,
        S_ISSUE
    } state_t;

    typedef enum logic [1:0] {
        OP_KEY,
        OP_IV,
        OP_START,
        OP_BAD
    } op_t;

    state_t                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [C_KEY_WIDTH-1:0]     stage_q, stage_d;
    op_t                        op_q, op_d;
    logic                       dir_q, dir_d;
    logic [C_KEY_WIDTH-1:0]     key_d, iv_d;
    logic                       key_load_d, iv_load_d;
    logic                       err_d;
    logic [C_ERR_CNT_WIDTH-1:0] err_cnt_d;

    logic [DW-1:0]          tdata;
    logic                   tlast;
    logic                   beat;
    logic                   flag_ok;
    logic [C_KEY_WIDTH-1:0] stage_shift;
    logic                   unused_tkeep;

    assign tdata   = m_axis_mm2s_cntrl.tdata;
    assign tlast   = m_axis_mm2s_cntrl.tlast;
    assign flag_ok = (tdata[DW-1 -: 4] == 4'hA);

    // No beat is taken while the reset is being applied.
    assign m_axis_mm2s_cntrl.tready =
        (state_q != S_ISSUE) && !mm2s_cntrl_reset;

    assign beat = m_axis_mm2s_cntrl.tvalid
                & m_axis_mm2s_cntrl.tready;

    assign stage_shift  = {stage_q[C_KEY_WIDTH-DW-1:0], tdata};
    assign unused_tkeep = ^m_axis_mm2s_cntrl.tkeep;

    assign aes_cmd_valid = (state_q == S_ISSUE);
    assign aes_cmd_dir   = aes_cmd_valid & dir_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        op_d       = op_q;
        dir_d      = dir_q;
        key_d      = aes_key;
        iv_d       = aes_iv;
        key_load_d = 1'b0;
        iv_load_d  = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = aes_cntrl_err_cnt;

        unique case (state_q)
            S_FLAG: begin
                if (beat) begin
                    if (flag_ok && !tlast) begin
                        state_d = S_APP0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = tlast ? S_FLAG : S_DRAIN;
                    end
                end
            end
            S_APP0: begin
                if (beat) begin
                    op_d  = op_t'(tdata[1:0]);
                    dir_d = tdata[8];
                    if (tlast) begin
                        err_d   = 1'b1;
                        state_d = S_FLAG;
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (beat) begin
                    stage_d = stage_shift;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q != LAST_BEAT) begin
                        if (tlast) begin
                            err_d   = 1'b1;
                            state_d = S_FLAG;
                        end
                    end else if (!tlast) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FLAG;
                        unique case (op_q)
                            OP_KEY: begin
                                key_d      = stage_shift;
                                key_load_d = 1'b1;
                            end
                            OP_IV: begin
                                iv_d      = stage_shift;
                                iv_load_d = 1'b1;
                            end
                            OP_START: state_d = S_ISSUE;
                            OP_BAD:   err_d   = 1'b1;
                        endcase
                    end
                end
            end
            S_DRAIN: begin
                if (beat && tlast) state_d = S_FLAG;
            end
            S_ISSUE: begin
                if (aes_cmd_ready) state_d = S_FLAG;
            end
            default: state_d = S_FLAG;
        endcase

        if (err_d && aes_cntrl_err_cnt != CNT_MAX) begin
            err_cnt_d = aes_cntrl_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge m_axi_mm2s_aclk) begin
        if (mm2s_cntrl_reset) begin
            state_q           <= S_FLAG;
            cnt_q             <= '0;
            stage_q           <= '0;
            op_q              <= OP_KEY;
            dir_q             <= 1'b0;
            aes_key           <= '0;
            aes_iv            <= '0;
            aes_key_load      <= 1'b0;
            aes_iv_load       <= 1'b0;
            aes_cntrl_err     <= 1'b0;
            aes_cntrl_err_cnt <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            stage_q           <= stage_d;
            op_q              <= op_d;
            dir_q             <= dir_d;
            aes_key           <= key_d;
            aes_iv            <= iv_d;
            aes_key_load      <= key_load_d;
            aes_iv_load       <= iv_load_d;
            aes_cntrl_err     <= err_d;
            aes_cntrl_err_cnt <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_aes_cntrl_parser.sv
// Randomized scoreboard bench for aes_cntrl_parser with a
// frame-level reference model.
module tb_aes_cntrl_parser;
    localparam int K_KEY = 0;
    localparam int K_IV  = 1;
    localparam int K_CMD = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int           kind;
        logic [127:0] key;
        logic [127:0] iv;
        logic [7:0]   cnt;
        logic         dir;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] aes_key, aes_iv;
    logic         key_load, iv_load;
    logic         cmd_valid, cmd_dir;
    logic         cmd_ready = 1'b0;
    logic         err;
    logic [7:0]   err_cnt;

    int           tests = 0;
    int           fails = 0;
    bit           rand_ready = 1'b0;
    exp_t         exp_q[$];
    logic [31:0]  frame_q[$];
    logic [127:0] m_key = '0;
    logic [127:0] m_iv = '0;
    logic [7:0]   m_cnt = '0;

    aes_cntrl_parser_if #(.DW(32)) cntrl ();

    aes_cntrl_parser dut (
        .m_axi_mm2s_aclk   (clk),
        .mm2s_cntrl_reset  (rst),
        .m_axis_mm2s_cntrl (cntrl),
        .aes_key           (aes_key),
        .aes_key_load      (key_load),
        .aes_iv            (aes_iv),
        .aes_iv_load       (iv_load),
        .aes_cmd_valid     (cmd_valid),
        .aes_cmd_dir       (cmd_dir),
        .aes_cmd_ready     (cmd_ready),
        .aes_cntrl_err     (err),
        .aes_cntrl_err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: simulation did not end");
        $fatal(1);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) cmd_ready = ($urandom_range(0, 2) == 0);
    end

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic pop_check(input int kind, input string nm);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s got unexpected pulse want none", nm);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            fails++;
            $display("FAIL %s kind got %0d want %0d", nm, kind, e.kind);
        end else if (aes_key !== e.key || aes_iv !== e.iv ||
                     err_cnt !== e.cnt ||
                     (kind == K_CMD && cmd_dir !== e.dir)) begin
            fails++;
            $display("FAIL %s got key=%h iv=%h cnt=%0d dir=%b want key=%h iv=%h cnt=%0d dir=%b",
                     nm, aes_key, aes_iv, err_cnt, cmd_dir,
                     e.key, e.iv, e.cnt, e.dir);
        end
    endtask

    // Monitor: every output event consumes one expected frame result.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (key_load) pop_check(K_KEY, "key_load");
            if (iv_load) pop_check(K_IV, "iv_load");
            if (err) pop_check(K_ERR, "err");
            if (cmd_valid) begin
                tests++;
                if (cntrl.tready !== 1'b0) begin
                    fails++;
                    $display("FAIL tready_in_issue got %b want 0", cntrl.tready);
                end
                if (cmd_ready) pop_check(K_CMD, "cmd");
            end
        end
    end

    // Whole-frame rules: only a 6-word frame with a good flag and a
    // legal op does anything other than raise one error.
    task automatic model_frame();
        exp_t        e;
        int          n;
        logic [31:0] app0;
        n      = frame_q.size();
        app0   = (n > 1) ? frame_q[1] : 32'h0;
        e.kind = K_ERR;
        if (frame_q[0][31:28] == 4'hA && n == 6) begin
            case (app0[1:0])
                2'd0: begin
                    e.kind = K_KEY;
                    m_key  = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
                end
                2'd1: begin
                    e.kind = K_IV;
                    m_iv   = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
                end
                2'd2: e.kind = K_CMD;
                default: e.kind = K_ERR;
            endcase
        end
        if (e.kind == K_ERR && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        e.key = m_key;
        e.iv  = m_iv;
        e.cnt = m_cnt;
        e.dir = app0[8];
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last,
                             input bit may_stall);
        int n;
        if (may_stall && $urandom_range(0, 3) == 0) begin
            cntrl.tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        cntrl.tdata  = d;
        cntrl.tlast  = last;
        cntrl.tvalid = 1'b1;
        n = 0;
        #1;
        while (cntrl.tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_word timeout tready got %b want 1", cntrl.tready);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit stall0);
        int n;
        model_frame();
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            send_word(frame_q[i], (i == n - 1), (i != 0) || stall0);
        end
        cntrl.tvalid = 1'b0;
    endtask

    task automatic build_good(input logic [1:0] op, input logic dir);
        logic [31:0] w;
        frame_q.delete();
        w = $urandom;
        frame_q.push_back({4'hA, w[27:0]});
        w      = $urandom;
        w[1:0] = op;
        w[8]   = dir;
        frame_q.push_back(w);
        for (int i = 0; i < 4; i++) frame_q.push_back($urandom);
    endtask

    task automatic build_len(input bit good_flag, input int len);
        logic [31:0] w;
        logic [3:0]  nib;
        frame_q.delete();
        w   = $urandom;
        nib = 4'hA;
        if (!good_flag) begin
            do nib = 4'($urandom_range(0, 15)); while (nib == 4'hA);
        end
        frame_q.push_back({nib, w[27:0]});
        for (int i = 1; i < len; i++) frame_q.push_back($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL wait_idle outstanding got %0d want 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        cntrl.tdata  = '0;
        cntrl.tkeep  = '1;
        cntrl.tvalid = 1'b0;
        cntrl.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_key", aes_key, '0);
        chk("rst_iv", aes_iv, '0);
        chk("rst_cnt", 128'(err_cnt), '0);
        chk("rst_outs", {key_load, iv_load, cmd_valid, cmd_dir, err}, '0);
        chk("rst_tready", 128'(cntrl.tready), 128'd1);
        @(negedge clk);

        // Known-answer key load
        frame_q = '{32'hA0000000, 32'h00000000, 32'h00010203,
                    32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        send_frame(1'b0);
        #1;
        chk("kat_key_load", 128'(key_load), 128'd1);
        chk("kat_key", aes_key, 128'h000102030405060708090A0B0C0D0E0F);
        chk("kat_iv_kept", aes_iv, '0);
        @(negedge clk);
        #1;
        chk("kat_key_load_pulse", 128'(key_load), '0);
        @(negedge clk);

        // START with a stalled AES core, then a back-to-back flag word
        rand_ready = 1'b0;
        cmd_ready  = 1'b0;
        frame_q = '{32'hA0000000, 32'h00000102, 32'h11111111,
                    32'h22222222, 32'h33333333, 32'h44444444};
        send_frame(1'b0);
        cntrl.tdata  = 32'hA0000000;
        cntrl.tlast  = 1'b0;
        cntrl.tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_ready = (i == 5);
            #1;
            chk("start_valid", {cmd_valid, cmd_dir, cntrl.tready}, 128'b110);
            @(negedge clk);
        end
        #1;
        chk("start_after_hs", {cmd_valid, cntrl.tready}, 128'b01);
        cmd_ready = 1'b0;
        build_good(2'd0, 1'b0);
        frame_q[0] = 32'hA0000000;
        send_frame(1'b0);
        wait_idle();

        // IV frame cut short, then a good IV frame
        frame_q = '{32'hA0000000, 32'h00000001, 32'hDEADBEEF, 32'hCAFEF00D};
        send_frame(1'b0);
        #1;
        chk("short_err", {err, iv_load}, 128'b10);
        chk("short_cnt", 128'(err_cnt), 128'd1);
        chk("short_iv_kept", aes_iv, '0);
        @(negedge clk);
        build_good(2'd1, 1'b0);
        send_frame(1'b1);
        wait_idle();

        // Bad flag with a long tail, then a good KEY
        build_len(1'b0, 8);
        frame_q[0] = 32'h50000000;
        send_frame(1'b1);
        build_good(2'd0, 1'b1);
        send_frame(1'b1);
        wait_idle();

        // Randomized mix
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5:
                    build_good(2'($urandom_range(0, 2)), 1'($urandom));
                6: build_good(2'd3, 1'($urandom));
                7: build_len(1'b0, $urandom_range(1, 9));
                default: build_len(1'b1, $urandom_range(1, 9));
            endcase
            send_frame(1'b1);
        end
        wait_idle();

        // Saturation of the error counter
        for (int f = 0; f < 260; f++) begin
            build_good(2'd3, 1'($urandom));
            send_frame(1'b1);
        end
        wait_idle();
        chk("sat_cnt", 128'(err_cnt), 128'd255);

        // Reset in the middle of a KEY payload
        build_good(2'd0, 1'b0);
        for (int i = 0; i < 3; i++) send_word(frame_q[i], 1'b0, 1'b1);
        cntrl.tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_key = '0;
        m_iv  = '0;
        m_cnt = '0;
        #1;
        chk("mid_rst_key", aes_key, '0);
        chk("mid_rst_iv", aes_iv, '0);
        chk("mid_rst_outs", {key_load, iv_load, cmd_valid, err, err_cnt}, '0);
        chk("mid_rst_tready", 128'(cntrl.tready), 128'd1);
        @(negedge clk);
        build_good(2'd0, 1'b0);
        send_frame(1'b1);
        wait_idle();
        chk("post_rst_key", aes_key, m_key);

        repeat (10) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_cntrl_parser.md
Name: aes_cntrl_parser

Overview:
- Consumes the AXI DMA MM2S control stream: one 6-word frame per descriptor (flag, APP0..APP4).
- Decodes each frame into an AES key load, an IV load, or a start command for the AES datapath.
- Sits directly downstream of the DMA control-stream port and upstream of the AES core's key/IV/command inputs.
- Key and IV registers are committed only on a well-formed frame; malformed frames are drained and counted.

Parameters:
C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH, 32, control stream width; only 32 is supported.
C_KEY_WIDTH, 128, key/IV width; built from APP1..APP4, APP1 most significant.
C_ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
m_axi_mm2s_aclk  in  1  sole clock
mm2s_cntrl_reset  in  1  synchronous, active-high reset
m_axis_mm2s_cntrl_tdata  in  32  control word
m_axis_mm2s_cntrl_tkeep  in  4  ignored; all-ones expected
m_axis_mm2s_cntrl_tvalid  in  1  word valid
m_axis_mm2s_cntrl_tlast  in  1  last word of frame
m_axis_mm2s_cntrl_tready  out  1  word accepted when tvalid&tready
aes_key  out  128  committed key
aes_key_load  out  1  1-cycle pulse; aes_key updated this cycle
aes_iv  out  128  committed IV
aes_iv_load  out  1  1-cycle pulse; aes_iv updated this cycle
aes_cmd_valid  out  1  start command valid
aes_cmd_dir  out  1  1 = encrypt, 0 = decrypt; stable while aes_cmd_valid
aes_cmd_ready  in  1  AES core accepts the command
aes_cntrl_err  out  1  1-cycle pulse per malformed frame
aes_cntrl_err_cnt  out  8  saturating count of malformed frames

Behaviour:
- Clock and reset: one clock, m_axi_mm2s_aclk; reset mm2s_cntrl_reset is synchronous and active-high.
- Reset values: all outputs 0, state FLAG, staging registers 0; aes_key, aes_iv and aes_cntrl_err_cnt cleared.
- Reset mid-frame or mid-ISSUE: frame abandoned, no commit, aes_cmd_valid drops on the next edge.
- Frame format:
  - word0 flag: bits[31:28] must be 0xA.
  - APP0 command: bits[1:0] op (0 = KEY, 1 = IV, 2 = START, 3 = illegal); bit[8] dir.
  - APP1..APP4: payload.
- States: FLAG, APP0, PAYLOAD (beat counter 1..4), DRAIN, ISSUE.
- tready: 1 in FLAG, APP0, PAYLOAD and DRAIN; 0 in ISSUE.
- FLAG:
  - Beat with bad flag and no tlast -> DRAIN.
  - Beat with bad flag and tlast -> error, stay in FLAG.
  - Good flag with tlast -> error, stay in FLAG.
  - Good flag otherwise -> APP0.
- APP0: latch op and dir into staging; tlast -> error, FLAG; else -> PAYLOAD with count = 1.
- PAYLOAD:
  - Each beat shifts into the 128-bit staging register (APP1 ends up in [127:96]).
  - tlast at count < 4 -> error, FLAG, no commit.
  - count = 4 without tlast -> error, DRAIN.
  - count = 4 with tlast -> commit.
- Commit, registered on the cycle after the last beat:
  - KEY: aes_key <= staging, aes_key_load = 1 for one cycle, -> FLAG.
  - IV: aes_iv <= staging, aes_iv_load = 1 for one cycle, -> FLAG.
  - START: -> ISSUE; aes_cmd_valid = 1 starting the cycle after the last beat; payload ignored.
  - op 3: error, no commit, -> FLAG.
- ISSUE: hold aes_cmd_valid and aes_cmd_dir until aes_cmd_valid & aes_cmd_ready; on that edge -> FLAG, valid drops next cycle. tready stays 0 throughout.
- DRAIN: accept and discard beats until a beat with tlast, then -> FLAG. The error is flagged on entry to DRAIN, once per frame.
- Error:
  - aes_cntrl_err pulses one cycle after the offending beat.
  - aes_cntrl_err_cnt increments on that pulse and saturates at 255 (no wrap).
- Back-to-back frames: a new frame's flag word is accepted the cycle after commit (KEY/IV) or after the ISSUE handshake. No bubble is required beyond that.
- tvalid low mid-frame stalls the state with no timeout.
- Key and IV are independent and persist across START commands until reloaded or reset.

Test Plan:
- KEY frame A0000000, 00000000, 00010203, 04050607, 08090A0B, 0C0D0E0F (tlast on word 6) -> one cycle after the last beat aes_key_load = 1 and aes_key = 000102030405060708090A0B0C0D0E0F; aes_iv unchanged; no error.
- START frame with APP0 = 00000102, aes_cmd_ready held 0 for 5 cycles then 1:
  - aes_cmd_valid = 1, aes_cmd_dir = 1 for 6 cycles; tready = 0 throughout.
  - The next frame's flag word is accepted in the cycle after the handshake.
- IV frame with tlast on APP2 (word 4) -> aes_cntrl_err pulse, err_cnt = 1, aes_iv unchanged, no aes_iv_load. A following good IV frame commits correctly.
- Flag word 50000000 followed by 7 words, tlast on word 8 -> all 8 words accepted, exactly one err pulse, no load; the next good KEY frame commits.
- 260 frames with op = 3 -> err_cnt reads 255 and holds; err still pulses per frame.
- Reset asserted for 1 cycle during PAYLOAD count 2 of a KEY frame -> all outputs 0 next cycle, aes_key = 0, state FLAG. The next complete KEY frame loads normally.
